// File: rtl/field_pkg.sv
// Shared definitions for the field-arithmetic pipeline: default sizes,
// the stage-1 state encoding and a small range-check helper.
package field_pkg;

   // Default operand width and field modulus, shared with the Barrett stage.
   localparam int WIDTH = 16;
   localparam int P     = 37;

   // Stage-1 controller states. All four 2-bit codes are used.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_ADD  = 2'd2,
      ST_HOLD = 2'd3
   } state_e;

   // True when an operand lies outside [0, m).
   function automatic logic out_of_field(input logic [31:0] x, input logic [31:0] m);
      return (x >= m);
   endfunction

endpackage

// File: rtl/shift_add_multiplier.sv
// Iterative radix-2 shift-add multiplier. A start pulse loads the operands;
// one partial product is added per clock for exactly `width` clocks.
// done_o is high during the final step, so product_o holds the full product
// from the edge that ends that step onwards until the next start.
module shift_add_multiplier #(
   parameter int width = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start_i,
   input  logic [width-1:0]     a_i,
   input  logic [width-1:0]     b_i,
   output logic                 done_o,
   output logic [2*width-1:0]   product_o
);

   localparam int CNT_W = $clog2(width + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(width - 1);

   logic [2*width-1:0] a_sh_q, a_sh_d;
   logic [width-1:0]   b_sh_q, b_sh_d;
   logic [2*width-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;

   // Next-state: load on start, otherwise take one shift-add step while busy.
   always_comb begin
      a_sh_d = a_sh_q;
      b_sh_d = b_sh_q;
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      if (start_i) begin
         a_sh_d = (2*width)'(a_i);
         b_sh_d = b_i;
         acc_d  = '0;
         cnt_d  = '0;
         busy_d = 1'b1;
      end else if (busy_q) begin
         acc_d  = acc_q + (b_sh_q[0] ? a_sh_q : '0);
         a_sh_d = a_sh_q << 1;
         b_sh_d = b_sh_q >> 1;
         cnt_d  = cnt_q + 1'b1;
         if (cnt_q == LAST) begin
            busy_d = 1'b0;
         end
      end
   end

   // Datapath registers; reset clears everything and aborts a running multiply.
   always_ff @(posedge clk) begin
      if (!reset) begin
         a_sh_q <= '0;
         b_sh_q <= '0;
         acc_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         a_sh_q <= a_sh_d;
         b_sh_q <= b_sh_d;
         acc_q  <= acc_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   assign done_o    = busy_q && (cnt_q == LAST);
   assign product_o = acc_q;

endmodule

// File: rtl/field_mul_add_stage.sv
// Stage 1 of the field pipeline: r = a*b + c - d as a signed 2*width value.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, is held with its data until that transfer.
// Only one operation is in flight; in_ready is high only in IDLE.
module field_mul_add_stage
   import field_pkg::*;
#(
   parameter int width = WIDTH,
   parameter int p     = P
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [width-1:0]            a,
   input  logic [width-1:0]            b,
   input  logic [width-1:0]            c,
   input  logic [width-1:0]            d,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic signed [2*width-1:0]   r,
   output logic                        range_err,
   output logic [1:0]                  dbg_state_o
);

   state_e             state_q, state_d;
   logic [width-1:0]   c_q, c_d;
   logic [width-1:0]   d_q, d_d;
   logic               err_q, err_d;
   logic [2*width-1:0] r_q, r_d;
   logic               out_valid_q, out_valid_d;
   logic               range_err_q, range_err_d;

   logic               accept;
   logic               mul_done;
   logic [2*width-1:0] mul_product;
   logic               any_out_of_range;

   assign accept = (state_q == ST_IDLE) && in_valid;

   assign any_out_of_range = out_of_field(32'(a), 32'(p)) | out_of_field(32'(b), 32'(p)) |
                             out_of_field(32'(c), 32'(p)) | out_of_field(32'(d), 32'(p));

   shift_add_multiplier #(.width(width)) u_mul (
      .clk       (clk),
      .reset     (reset),
      .start_i   (accept),
      .a_i       (a),
      .b_i       (b),
      .done_o    (mul_done),
      .product_o (mul_product)
   );

   // Controller next-state and register updates for the operand/output registers.
   always_comb begin
      state_d     = state_q;
      c_d         = c_q;
      d_d         = d_q;
      err_d       = err_q;
      r_d         = r_q;
      out_valid_d = out_valid_q;
      range_err_d = range_err_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               c_d     = c;
               d_d     = d;
               err_d   = any_out_of_range;
               state_d = ST_MUL;
            end
         end
         ST_MUL: begin
            if (mul_done) begin
               state_d = ST_ADD;
            end
         end
         ST_ADD: begin
            // Extra top bit keeps the subtraction exact before truncation.
            r_d = (2*width)'({1'b0, mul_product} + (2*width+1)'(c_q) - (2*width+1)'(d_q));
            out_valid_d = 1'b1;
            range_err_d = err_q;
            state_d     = ST_HOLD;
         end
         ST_HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               range_err_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and data registers; reset wins over any handshake in flight.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         c_q         <= '0;
         d_q         <= '0;
         err_q       <= 1'b0;
         r_q         <= '0;
         out_valid_q <= 1'b0;
         range_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         c_q         <= c_d;
         d_q         <= d_d;
         err_q       <= err_d;
         r_q         <= r_d;
         out_valid_q <= out_valid_d;
         range_err_q <= range_err_d;
      end
   end

   assign in_ready    = (state_q == ST_IDLE);
   assign out_valid   = out_valid_q;
   assign r           = r_q;
   assign range_err   = range_err_q;
   assign dbg_state_o = state_q;

endmodule
